// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file with write-through bypass,
// load-use/branch hazard detection, early BEQ/BNE/JAL resolution and a registered ID/EX bundle.
module id_stage #(
    parameter int N    = 32,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc,
    input  logic [31:0]  inst,
    output logic [N-1:0] pc_branch,
    output logic         branch_zero,
    output logic         pc_hold,
    input  logic         ex_mem_read,
    input  logic         ex_reg_write,
    input  logic [4:0]   ex_rd,
    input  logic         mem_reg_write,
    input  logic [4:0]   mem_rd,
    input  logic         wb_we,
    input  logic [4:0]   wb_rd,
    input  logic [N-1:0] wb_data,
    output logic         idex_valid,
    output logic [N-1:0] idex_pc,
    output logic [N-1:0] idex_rs1_data,
    output logic [N-1:0] idex_rs2_data,
    output logic [N-1:0] idex_imm,
    output logic [4:0]   idex_rd,
    output logic [6:0]   idex_opcode,
    output logic [2:0]   idex_funct3,
    output logic         idex_funct7b5
);

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic         if_valid_q, if_valid_d;
    logic [N-1:0] if_pc_q, if_pc_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic [N-1:0] rf_q [NREG];

    logic [6:0]   opcode;
    logic [4:0]   rs1, rs2, rd;
    logic [2:0]   funct3;
    logic [31:0]  imm32;
    logic [N-1:0] imm, rs1_data, rs2_data;
    logic         uses_rs2, is_beq, is_bne, is_jal;
    logic         rs1_busy, rs2_busy, load_use, branch_stall, taken;

    logic         idex_valid_q, idex_valid_d;
    logic [N-1:0] idex_pc_q, idex_pc_d;
    logic [N-1:0] idex_rs1_q, idex_rs1_d;
    logic [N-1:0] idex_rs2_q, idex_rs2_d;
    logic [N-1:0] idex_imm_q, idex_imm_d;
    logic [4:0]   idex_rd_q, idex_rd_d;
    logic [6:0]   idex_opcode_q, idex_opcode_d;
    logic [2:0]   idex_funct3_q, idex_funct3_d;
    logic         idex_f7b5_q, idex_f7b5_d;

    assign opcode = if_inst_q[6:0];
    assign rd     = if_inst_q[11:7];
    assign funct3 = if_inst_q[14:12];
    assign rs1    = if_inst_q[19:15];
    assign rs2    = if_inst_q[24:20];

    always_comb begin
        // NOTE: default assigned first so opcodes without an immediate cannot infer a latch.
        imm32 = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{if_inst_q[31]}}, if_inst_q[31:20]};
            OP_STORE:  imm32 = {{20{if_inst_q[31]}}, if_inst_q[31:25], if_inst_q[11:7]};
            OP_BRANCH: imm32 = {{19{if_inst_q[31]}}, if_inst_q[31], if_inst_q[7],
                                if_inst_q[30:25], if_inst_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {if_inst_q[31:12], 12'b0};
            OP_JAL:    imm32 = {{11{if_inst_q[31]}}, if_inst_q[31], if_inst_q[19:12],
                                if_inst_q[20], if_inst_q[30:21], 1'b0};
            default:   imm32 = '0;
        endcase
    end
    assign imm = N'($signed(imm32));

    // x0 reads as zero; a same-cycle writeback is forwarded so a stalled source sees it at once.
    assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_we && wb_rd == rs1) ? wb_data : rf_q[rs1];
    assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_we && wb_rd == rs2) ? wb_data : rf_q[rs2];

    assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);
    assign is_bne   = (opcode == OP_BRANCH) && (funct3 == 3'b001);
    assign is_jal   = (opcode == OP_JAL);

    assign rs1_busy = (rs1 != 5'd0) && ((ex_reg_write && ex_rd == rs1) || (mem_reg_write && mem_rd == rs1));
    assign rs2_busy = (rs2 != 5'd0) && ((ex_reg_write && ex_rd == rs2) || (mem_reg_write && mem_rd == rs2));
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
    assign branch_stall = (is_beq || is_bne) && (rs1_busy || rs2_busy);

    assign pc_hold     = if_valid_q && (load_use || branch_stall);
    assign taken       = (is_beq && rs1_data == rs2_data) || (is_bne && rs1_data != rs2_data) || is_jal;
    assign branch_zero = if_valid_q && taken && !pc_hold;
    assign pc_branch   = if_pc_q + imm;

    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if (!pc_hold) begin
            if_valid_d = !branch_zero;
            if_pc_d    = pc;
            if_inst_d  = inst;
        end
    end

    always_comb begin
        idex_valid_d  = if_valid_q && !pc_hold;
        idex_pc_d     = '0;
        idex_rs1_d    = '0;
        idex_rs2_d    = '0;
        idex_imm_d    = '0;
        idex_rd_d     = '0;
        idex_opcode_d = '0;
        idex_funct3_d = '0;
        idex_f7b5_d   = 1'b0;
        if (idex_valid_d) begin
            idex_pc_d     = if_pc_q;
            idex_rs1_d    = rs1_data;
            idex_rs2_d    = rs2_data;
            idex_imm_d    = imm;
            idex_rd_d     = rd;
            idex_opcode_d = opcode;
            idex_funct3_d = funct3;
            idex_f7b5_d   = if_inst_q[30];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking updates so every register samples pre-edge values.
        if (reset) begin
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_inst_q     <= NOP;
            idex_valid_q  <= 1'b0;
            idex_pc_q     <= '0;
            idex_rs1_q    <= '0;
            idex_rs2_q    <= '0;
            idex_imm_q    <= '0;
            idex_rd_q     <= '0;
            idex_opcode_q <= '0;
            idex_funct3_q <= '0;
            idex_f7b5_q   <= 1'b0;
        end else begin
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
            idex_valid_q  <= idex_valid_d;
            idex_pc_q     <= idex_pc_d;
            idex_rs1_q    <= idex_rs1_d;
            idex_rs2_q    <= idex_rs2_d;
            idex_imm_q    <= idex_imm_d;
            idex_rd_q     <= idex_rd_d;
            idex_opcode_q <= idex_opcode_d;
            idex_funct3_q <= idex_funct3_d;
            idex_f7b5_q   <= idex_f7b5_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the register file is built from flops so reset can clear every entry.
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    assign idex_valid    = idex_valid_q;
    assign idex_pc       = idex_pc_q;
    assign idex_rs1_data = idex_rs1_q;
    assign idex_rs2_data = idex_rs2_q;
    assign idex_imm      = idex_imm_q;
    assign idex_rd       = idex_rd_q;
    assign idex_opcode   = idex_opcode_q;
    assign idex_funct3   = idex_funct3_q;
    assign idex_funct7b5 = idex_f7b5_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed hazard/branch/reset scenarios followed by
// random traffic, all compared against a cycle-level reference model of the decode stage.
module tb_id_stage;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] pc;
    logic [31:0]  inst;
    logic [N-1:0] pc_branch;
    logic         branch_zero, pc_hold;
    logic         ex_mem_read, ex_reg_write, mem_reg_write, wb_we;
    logic [4:0]   ex_rd, mem_rd, wb_rd;
    logic [N-1:0] wb_data;
    logic         idex_valid, idex_funct7b5;
    logic [N-1:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
    logic [4:0]   idex_rd;
    logic [6:0]   idex_opcode;
    logic [2:0]   idex_funct3;

    int n_checks = 0;
    int n_errors = 0;

    id_stage #(.N(N), .NREG(32)) dut (
        .clk(clk), .reset(reset), .pc(pc), .inst(inst),
        .pc_branch(pc_branch), .branch_zero(branch_zero), .pc_hold(pc_hold),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data),
        .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm), .idex_rd(idex_rd),
        .idex_opcode(idex_opcode), .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5)
    );

    always #5 clk = ~clk;

    // Reference model state: architectural registers, the instruction sitting in decode,
    // and the bundle expected on the ID/EX outputs.
    logic [31:0] m_regs [32];
    logic        m_v;
    logic [31:0] m_pc, m_inst;
    logic        m_hold, m_bz;
    logic [31:0] m_a, m_b, m_target;
    logic        e_valid, e_f7;
    logic [31:0] e_pc, e_rs1, e_rs2, e_imm;
    logic [4:0]  e_rd;
    logic [6:0]  e_opc;
    logic [2:0]  e_f3;
    logic        obs_hold, obs_bz;
    logic [31:0] obs_pcb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {f7, r2, r1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
        return {im, r1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {off[12], off[10:5], r2, r1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] d);
        return {off[20], off[10:1], off[11], off[19:12], d, 7'b1101111};
    endfunction

    // Immediate value worked out arithmetically from the field positions of each format.
    function automatic logic [31:0] ref_imm(input logic [31:0] x);
        int v;
        case (x[6:0])
            7'h03, 7'h13, 7'h67: return 32'($signed(x) >>> 20);
            7'h23: return (32'($signed(x) >>> 20) & ~32'h1f) | 32'(x[11:7]);
            7'h63: begin
                v = int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
                if (x[31]) v -= 4096;
                return 32'(v);
            end
            7'h37, 7'h17: return x & 32'hFFFFF000;
            7'h6f: begin
                v = int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
                if (x[31]) v -= (1 << 20);
                return 32'(v);
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (wb_we && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_v = 1'b0; m_pc = '0; m_inst = 32'h00000013;
        e_valid = 1'b0; e_pc = '0; e_rs1 = '0; e_rs2 = '0; e_imm = '0;
        e_rd = '0; e_opc = '0; e_f3 = '0; e_f7 = 1'b0;
    endtask

    task automatic model_eval();
        logic [6:0] op;
        logic [4:0] s1, s2;
        logic [2:0] f3;
        logic       two, lu, cond, dep1, dep2, bs, tk;
        op = m_inst[6:0]; s1 = m_inst[19:15]; s2 = m_inst[24:20]; f3 = m_inst[14:12];
        m_a = ref_read(s1);
        m_b = ref_read(s2);
        two  = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
        lu   = ex_mem_read && ex_rd != 0 && (ex_rd == s1 || (two && ex_rd == s2));
        cond = (op == 7'h63) && (f3 == 3'd0 || f3 == 3'd1);
        dep1 = s1 != 0 && ((ex_reg_write && ex_rd == s1) || (mem_reg_write && mem_rd == s1));
        dep2 = s2 != 0 && ((ex_reg_write && ex_rd == s2) || (mem_reg_write && mem_rd == s2));
        bs   = cond && (dep1 || dep2);
        m_hold = m_v && (lu || bs);
        tk = (op == 7'h63 && f3 == 3'd0 && m_a == m_b) ||
             (op == 7'h63 && f3 == 3'd1 && m_a != m_b) || (op == 7'h6f);
        m_bz = m_v && tk && !m_hold;
        m_target = m_pc + ref_imm(m_inst);
    endtask

    task automatic model_edge();
        e_valid = m_v && !m_hold;
        e_pc  = e_valid ? m_pc : '0;
        e_rs1 = e_valid ? m_a : '0;
        e_rs2 = e_valid ? m_b : '0;
        e_imm = e_valid ? ref_imm(m_inst) : '0;
        e_rd  = e_valid ? m_inst[11:7] : '0;
        e_opc = e_valid ? m_inst[6:0] : '0;
        e_f3  = e_valid ? m_inst[14:12] : '0;
        e_f7  = e_valid ? m_inst[30] : 1'b0;
        if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
        if (!m_hold) begin
            m_v = !m_bz; m_pc = pc; m_inst = inst;
        end
    endtask

    // One clock: compare fetch-side outputs mid-cycle, then the ID/EX bundle just after the edge.
    task automatic cycle();
        @(negedge clk);
        model_eval();
        obs_hold = pc_hold; obs_bz = branch_zero; obs_pcb = pc_branch;
        chk("pc_hold", 32'(pc_hold), 32'(m_hold));
        chk("branch_zero", 32'(branch_zero), 32'(m_bz));
        chk("pc_branch", pc_branch, m_target);
        @(posedge clk);
        model_edge();
        #1;
        chk("idex_valid", 32'(idex_valid), 32'(e_valid));
        chk("idex_pc", idex_pc, e_pc);
        chk("idex_rs1_data", idex_rs1_data, e_rs1);
        chk("idex_rs2_data", idex_rs2_data, e_rs2);
        chk("idex_imm", idex_imm, e_imm);
        chk("idex_rd", 32'(idex_rd), 32'(e_rd));
        chk("idex_opcode", 32'(idex_opcode), 32'(e_opc));
        chk("idex_funct3", 32'(idex_funct3), 32'(e_f3));
        chk("idex_funct7b5", 32'(idex_funct7b5), 32'(e_f7));
    endtask

    task automatic idle();
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = '0;
        mem_reg_write = 0; mem_rd = '0;
        wb_we = 0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] i);
        pc = p; inst = i;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_we = 1; wb_rd = r; wb_data = d;
    endtask

    initial begin
        logic [31:0] raw;
        logic [6:0]  op;
        logic [2:0]  f3;
        idle();
        drive(32'h0, 32'h00000013);

        // Power-on reset
        #1 reset = 1'b1;
        #1;
        chk("por_pc_hold", 32'(pc_hold), 32'h0);
        chk("por_branch_zero", 32'(branch_zero), 32'h0);
        chk("por_idex_valid", 32'(idex_valid), 32'h0);
        model_reset();
        @(posedge clk); #1 reset = 1'b0;

        // Writeback x3/x5 then ADD x4,x3,x0 at 0x10
        wb(5'd3, 32'hDEADBEEF); drive(32'h0c, 32'h00000013); cycle();
        wb(5'd5, 32'h00000055); drive(32'h10, enc_r(7'h0, 5'd0, 5'd3, 3'd0, 5'd4, 7'h33)); cycle();
        idle(); drive(32'h14, enc_i(12'd1, 5'd6, 3'd0, 5'd7, 7'h13)); cycle();
        chk("add_rs1_data", idex_rs1_data, 32'hDEADBEEF);
        chk("add_rd", 32'(idex_rd), 32'd4);
        chk("add_valid", 32'(idex_valid), 32'd1);
        chk("add_pc", idex_pc, 32'h10);

        // Load-use: LW x6 in EX while ADDI x7,x6,1 is in ID
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd6; drive(32'h18, 32'h00000013); cycle();
        chk("lu_hold", 32'(obs_hold), 32'd1);
        chk("lu_bubble", 32'(idex_valid), 32'd0);
        idle(); cycle();
        chk("lu_release", 32'(obs_hold), 32'd0);
        chk("lu_addi_valid", 32'(idex_valid), 32'd1);
        chk("lu_addi_rd", 32'(idex_rd), 32'd7);
        chk("lu_addi_imm", idex_imm, 32'd1);

        // BEQ x1,x2,+8 at 0x20, taken then not taken
        wb(5'd1, 32'd5); drive(32'h1c, 32'h00000013); cycle();
        wb(5'd2, 32'd5); drive(32'h20, enc_b(13'd8, 5'd2, 5'd1, 3'd0)); cycle();
        idle(); drive(32'h24, enc_i(12'd1, 5'd0, 3'd0, 5'd10, 7'h13)); cycle();
        chk("beq_taken", 32'(obs_bz), 32'd1);
        chk("beq_target", obs_pcb, 32'h28);
        drive(32'h28, enc_b(13'd8, 5'd3, 5'd1, 3'd0)); cycle();
        chk("beq_flush_bubble", 32'(idex_valid), 32'd0);
        drive(32'h2c, 32'h00000013); cycle();
        chk("beq_not_taken", 32'(obs_bz), 32'd0);

        // JAL -4 at pc 0 wraps; x0 writes are discarded
        drive(32'h0, enc_j(21'h1FFFFC, 5'd1)); cycle();
        drive(32'h4, 32'h00000013); cycle();
        chk("jal_taken", 32'(obs_bz), 32'd1);
        chk("jal_wrap_target", obs_pcb, 32'hFFFFFFFC);
        wb(5'd0, 32'd5); drive(32'hFFFFFFFC, enc_r(7'h0, 5'd0, 5'd0, 3'd0, 5'd8, 7'h33)); cycle();
        drive(32'h0, 32'h00000013); cycle();
        chk("x0_read_zero", idex_rs1_data, 32'h0);
        chk("x0_read_valid", 32'(idex_valid), 32'd1);

        // BNE x9,x0 while MEM writes x9, resolved through the WB bypass
        idle(); drive(32'h40, enc_b(13'd16, 5'd0, 5'd9, 3'd1)); cycle();
        mem_reg_write = 1; mem_rd = 5'd9; drive(32'h44, 32'h00000013); cycle();
        chk("bne_stall_hold", 32'(obs_hold), 32'd1);
        chk("bne_stall_no_redirect", 32'(obs_bz), 32'd0);
        idle(); wb(5'd9, 32'd7); cycle();
        chk("bne_release", 32'(obs_hold), 32'd0);
        chk("bne_taken", 32'(obs_bz), 32'd1);
        chk("bne_target", obs_pcb, 32'h50);

        // Reset asserted in the middle of a load-use stall
        idle(); drive(32'h60, enc_r(7'h0, 5'd0, 5'd5, 3'd0, 5'd11, 7'h33)); cycle();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5;
        #2;
        chk("pre_reset_hold", 32'(pc_hold), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_idex_valid", 32'(idex_valid), 32'd0);
        chk("rst_pc_hold", 32'(pc_hold), 32'd0);
        chk("rst_branch_zero", 32'(branch_zero), 32'd0);
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        idle(); drive(32'h64, enc_r(7'h0, 5'd0, 5'd5, 3'd0, 5'd12, 7'h33)); cycle();
        chk("rst_first_id_invalid", 32'(idex_valid), 32'd0);
        drive(32'h68, 32'h00000013); cycle();
        chk("rst_x5_cleared", idex_rs1_data, 32'h0);
        chk("rst_x5_valid", 32'(idex_valid), 32'd1);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            raw = $urandom;
            f3 = 3'(raw[14:12]);
            case ($urandom_range(0, 9))
                0: op = 7'h33;
                1: op = 7'h13;
                2: op = 7'h03;
                3: op = 7'h23;
                4, 5: begin op = 7'h63; f3 = 3'($urandom_range(0, 3)); end
                6: op = ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17;
                7: op = 7'h6f;
                8: op = 7'h67;
                default: op = 7'(raw[6:0]);
            endcase
            drive({$urandom} & 32'hFFFFFFFC,
                  {raw[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3, raw[11:7], op});
            ex_mem_read   = ($urandom_range(0, 3) == 0);
            ex_reg_write  = ex_mem_read | ($urandom_range(0, 2) == 0);
            ex_rd         = 5'($urandom_range(0, 7));
            mem_reg_write = ($urandom_range(0, 2) == 0);
            mem_rd        = 5'($urandom_range(0, 7));
            wb_we         = ($urandom_range(0, 1) == 1);
            wb_rd         = 5'($urandom_range(0, 7));
            wb_data       = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
